// File: rtl/button_event_gen_pkg.sv
// Shared encodings for the button front-end: per-channel FSM states and the
// counter-control opcodes also used by the debouncer's register block.
package button_event_gen_pkg;

    typedef enum logic [1:0] {
        ST_LOCKOUT = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PRESSED = 2'd2,
        ST_REPEAT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CTRL_NONE = 2'd0,
        CTRL_CLR  = 2'd1,
        CTRL_LOAD = 2'd2,
        CTRL_INCR = 2'd3
    } ctrl_e;

endpackage

// File: rtl/button_event_gen_if.sv
// Button level inputs and the event outputs derived from them.
// master: the side driving levels and consuming events; slave: the event generator.
interface button_event_gen_if #(
    parameter int unsigned SIGNAL_NUM = 1
) ();

    logic [SIGNAL_NUM-1:0] signal_input;
    logic [SIGNAL_NUM-1:0] press_pulse;
    logic [SIGNAL_NUM-1:0] release_pulse;
    logic [SIGNAL_NUM-1:0] repeat_pulse;
    logic [SIGNAL_NUM-1:0] held;

    modport master (
        output signal_input,
        input  press_pulse,
        input  release_pulse,
        input  repeat_pulse,
        input  held
    );

    modport slave (
        input  signal_input,
        output press_pulse,
        output release_pulse,
        output repeat_pulse,
        output held
    );

endinterface

// File: rtl/button_event_gen_fsm.sv
// Single-channel press/release/auto-repeat event FSM with its tick counter.
// All outputs are registered; release always wins over a coincident expiry.
module button_event_gen_fsm
    import button_event_gen_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 25,
    parameter int unsigned HOLD_TICKS    = 25_000_000,
    parameter int unsigned REPEAT_TICKS  = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_in,
    output logic o_press,
    output logic o_release,
    output logic o_repeat,
    output logic o_held
);

    localparam logic [COUNTER_WIDTH-1:0] HoldLast   = COUNTER_WIDTH'(HOLD_TICKS - 1);
    localparam logic [COUNTER_WIDTH-1:0] RepeatLast = COUNTER_WIDTH'(REPEAT_TICKS - 1);
    localparam logic [COUNTER_WIDTH-1:0] CountOne   = COUNTER_WIDTH'(1);

    state_e                   r_state;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic                     r_press;
    logic                     r_release;
    logic                     r_repeat;
    logic                     r_held;

    ctrl_e                    w_ctrl;
    logic                     w_hold_done;
    logic                     w_rep_done;

    assign w_hold_done = (r_count == HoldLast);
    assign w_rep_done  = (r_count == RepeatLast);

    // Counter control: clear on entry to a timed phase and at each expiry, else count.
    always_comb begin
        w_ctrl = CTRL_NONE;
        case (r_state)
            ST_LOCKOUT: w_ctrl = CTRL_CLR;
            ST_IDLE:    w_ctrl = i_in ? CTRL_CLR : CTRL_NONE;
            ST_PRESSED: w_ctrl = w_hold_done ? CTRL_CLR : CTRL_INCR;
            ST_REPEAT:  w_ctrl = w_rep_done ? CTRL_CLR : CTRL_INCR;
            default:    w_ctrl = CTRL_NONE;
        endcase
    end

    // Tick counter register block; LOAD is not used by this channel and holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case (w_ctrl)
                CTRL_CLR:  r_count <= '0;
                CTRL_INCR: r_count <= r_count + CountOne;
                default:   r_count <= r_count;
            endcase
        end
    end

    // Channel FSM with registered event pulses and held level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_LOCKOUT;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            case (r_state)
                // A button held through reset must be released before it can press.
                ST_LOCKOUT: begin
                    r_held <= 1'b0;
                    if (!i_in) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    r_held <= 1'b0;
                    if (i_in) begin
                        r_state <= ST_PRESSED;
                        r_press <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!i_in) begin
                        r_state   <= ST_IDLE;
                        r_release <= 1'b1;
                    end else if (w_hold_done) begin
                        r_state  <= ST_REPEAT;
                        r_repeat <= 1'b1;
                        r_held   <= 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!i_in) begin
                        r_state   <= ST_IDLE;
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                    end else if (w_rep_done) begin
                        r_repeat <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_LOCKOUT;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;
    assign o_held    = r_held;

endmodule

// File: rtl/button_event_gen.sv
// Converts debounced button levels into press/release/auto-repeat events,
// one independent FSM and counter per channel.
module button_event_gen #(
    parameter int unsigned SIGNAL_NUM    = 1,
    parameter int unsigned COUNTER_WIDTH = 25,
    parameter int unsigned HOLD_TICKS    = 25_000_000,
    parameter int unsigned REPEAT_TICKS  = 5_000_000
) (
    input  logic               clk,
    input  logic               rst,
    button_event_gen_if.slave  bus
);

    logic [SIGNAL_NUM-1:0] w_press;
    logic [SIGNAL_NUM-1:0] w_release;
    logic [SIGNAL_NUM-1:0] w_repeat;
    logic [SIGNAL_NUM-1:0] w_held;

    // One channel FSM per button.
    for (genvar g = 0; g < SIGNAL_NUM; g++) begin : g_chan
        button_event_gen_fsm #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .HOLD_TICKS    (HOLD_TICKS),
            .REPEAT_TICKS  (REPEAT_TICKS)
        ) u_fsm (
            .clk       (clk),
            .rst       (rst),
            .i_in      (bus.signal_input[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g]),
            .o_repeat  (w_repeat[g]),
            .o_held    (w_held[g])
        );
    end

    assign bus.press_pulse   = w_press;
    assign bus.release_pulse = w_release;
    assign bus.repeat_pulse  = w_repeat;
    assign bus.held          = w_held;

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: directed scenarios then random levels, checked
// every cycle against an event model based on time-since-press.
module tb_button_event_gen;

    localparam int unsigned N    = 2;
    localparam int unsigned CW   = 8;
    localparam int unsigned HOLD = 8;
    localparam int unsigned REP  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    button_event_gen_if #(.SIGNAL_NUM(N)) bus ();

    button_event_gen #(
        .SIGNAL_NUM    (N),
        .COUNTER_WIDTH (CW),
        .HOLD_TICKS    (HOLD),
        .REPEAT_TICKS  (REP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: locked until released after reset; when down, age = cycles since press pulse.
    bit m_locked [N];
    bit m_down   [N];
    int m_age    [N];
    logic [N-1:0] e_press, e_rel, e_rep, e_held;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
    endtask

    task automatic model(input logic r, input logic [N-1:0] in);
        e_press = '0;
        e_rel   = '0;
        e_rep   = '0;
        e_held  = '0;
        for (int c = 0; c < N; c++) begin
            if (r) begin
                m_locked[c] = 1'b1;
                m_down[c]   = 1'b0;
                m_age[c]    = 0;
            end else if (m_locked[c]) begin
                if (!in[c]) m_locked[c] = 1'b0;
            end else if (!m_down[c]) begin
                if (in[c]) begin
                    m_down[c]  = 1'b1;
                    m_age[c]   = 0;
                    e_press[c] = 1'b1;
                end
            end else if (!in[c]) begin
                m_down[c] = 1'b0;
                e_rel[c]  = 1'b1;
            end else begin
                m_age[c] = m_age[c] + 1;
                if (m_age[c] >= int'(HOLD)) begin
                    e_held[c] = 1'b1;
                    if ((m_age[c] - int'(HOLD)) % int'(REP) == 0) e_rep[c] = 1'b1;
                end
            end
        end
    endtask

    task automatic tick(input logic r, input logic [N-1:0] in);
        rst              = r;
        bus.signal_input = in;
        model(r, in);
        @(posedge clk);
        #1;
        cyc++;
        check("press_pulse", bus.press_pulse, e_press);
        check("release_pulse", bus.release_pulse, e_rel);
        check("repeat_pulse", bus.repeat_pulse, e_rep);
        check("held", bus.held, e_held);
    endtask

    task automatic reset_to(input logic [N-1:0] in);
        tick(1'b1, in);
        tick(1'b1, in);
    endtask

    initial begin
        logic [N-1:0] v;
        logic [N-1:0] lvl;
        int           dur [N];
        int           oc;

        for (int c = 0; c < N; c++) begin
            m_locked[c] = 1'b1;
            m_down[c]   = 1'b0;
            m_age[c]    = 0;
        end

        // Press at 5, held through repeats, release at 25.
        reset_to('0);
        for (int t = 0; t < 30; t++) begin
            v = '0;
            v[0] = (t >= 5 && t < 25);
            tick(1'b0, v);
            oc = t + 1;
            if (oc == 6) check("dir_press6", bus.press_pulse, 2'b01);
            if (oc == 14 || oc == 17 || oc == 20 || oc == 23)
                check("dir_repeat", bus.repeat_pulse, 2'b01);
            if (oc == 14) check("dir_held14", bus.held, 2'b01);
            if (oc == 26) begin
                check("dir_release26", bus.release_pulse, 2'b01);
                check("dir_held26", bus.held, 2'b00);
            end
        end

        // Held through reset: only the press after a real release counts.
        reset_to(2'b01);
        for (int t = 0; t < 16; t++) begin
            v = '0;
            v[0] = !(t >= 10 && t < 12);
            tick(1'b0, v);
            oc = t + 1;
            if (oc < 13) check("dir_lockout_nopress", bus.press_pulse, 2'b00);
            if (oc == 13) check("dir_press13", bus.press_pulse, 2'b01);
        end

        // Release just before and exactly at hold expiry.
        for (int k = 12; k <= 13; k++) begin
            reset_to('0);
            for (int t = 0; t < 18; t++) begin
                v = '0;
                v[0] = (t >= 5 && t < k);
                tick(1'b0, v);
                oc = t + 1;
                if (oc == k + 1) begin
                    check("dir_early_release", bus.release_pulse, 2'b01);
                    check("dir_early_norepeat", bus.repeat_pulse, 2'b00);
                    check("dir_early_held", bus.held, 2'b00);
                end
            end
        end

        // Both channels together, reset while held, lockout until release.
        reset_to('0);
        for (int t = 0; t < 24; t++) begin
            v = ((t >= 5 && t < 15) || t >= 18) ? 2'b11 : 2'b00;
            tick(t == 10, v);
            oc = t + 1;
            if (oc == 6) check("dir_both_press", bus.press_pulse, 2'b11);
            if (oc >= 11 && oc <= 18)
                check("dir_quiet", bus.press_pulse | bus.release_pulse | bus.repeat_pulse
                      | bus.held, 2'b00);
            if (oc == 19) check("dir_both_repress", bus.press_pulse, 2'b11);
        end

        // Random held/released durations with occasional reset.
        reset_to('0);
        lvl = '0;
        for (int c = 0; c < N; c++) dur[c] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < N; c++) begin
                if (dur[c] == 0) begin
                    lvl[c] = ~lvl[c];
                    dur[c] = int'($urandom_range(1, 30));
                end
                dur[c] = dur[c] - 1;
            end
            tick($urandom_range(0, 199) == 0, lvl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
